// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl_pkg
// Purpose : Shared types and constants for the LC-3 memory access sequencer.
//           Holds the sequencer state encoding, the MARMUX select values and
//           the MDR input source values.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    RD_PTR = 3'd2,
    IND    = 3'd3,
    WDATA  = 3'd4,
    WR     = 3'd5,
    RD     = 3'd6,
    DONE   = 3'd7
  } state_t;

  // MARMUX select values.
  localparam logic SEL_ADDER = 1'b1;
  localparam logic SEL_ZEXT  = 1'b0;

  // MDR input source values.
  localparam logic MDR_SRC_MEM = 1'b1;
  localparam logic MDR_SRC_BUS = 1'b0;

  // States in which the sequencer waits on the memory handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == RD_PTR) || (s == RD) || (s == WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_timer
// Purpose : Counts the cycles a memory phase waits for mem_ready and flags
//           the cycle in which the wait budget is used up.
// Ports   : clk     - system clock, rising edge
//           rst_n   - asynchronous active-low reset
//           clear   - synchronous counter clear
//           cnt_en  - count this cycle (memory not ready)
//           expired - this counting cycle brings the count to TIMEOUT_CYCLES
// Revision: 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (cnt_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expiry is flagged in the cycle whose low mem_ready would take the count
  // to TIMEOUT_CYCLES, so the phase ends after exactly TIMEOUT_CYCLES waits.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = cnt_en && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl
// Purpose : Sequences one LC-3 memory access (LD/ST/LDR/STR/LDI/STI) through
//           the MARMUX/MAR/MDR path and the memory handshake, then pulses done.
// Ports   : clk, rst_n                   - clock / async active-low reset
//           req_valid, req_ready         - request handshake
//           req_write, req_indirect      - store / indirect (pointer) access
//           req_addr_sel                 - MARMUX select for first address
//           mem_ready                    - memory ready (R)
//           marmux_sel, gate_marmux      - MARMUX select and bus gate
//           gate_mdr, gate_alu           - MDR / ALU bus gates
//           ld_mar, ld_mdr, mdr_from_mem - MAR/MDR loads, MDR source
//           mio_en, r_w                  - memory enable and direction
//           done, err                    - completion pulse, timeout flag
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic req_indirect,
  input  logic req_addr_sel,
  input  logic mem_ready,
  output logic marmux_sel,
  output logic gate_marmux,
  output logic gate_mdr,
  output logic gate_alu,
  output logic ld_mar,
  output logic ld_mdr,
  output logic mdr_from_mem,
  output logic mio_en,
  output logic r_w,
  output logic done,
  output logic err
);

  state_t r_state;
  state_t w_next_state;

  logic r_write;
  logic r_indirect;
  logic r_addr_sel;
  logic r_tmo_flag;

  logic w_in_wait;
  logic w_cnt_en;
  logic w_expired;

  assign w_in_wait = is_wait_state(r_state);
  assign w_cnt_en  = w_in_wait && !mem_ready;

  // Counter is held clear outside the wait states, which clears it on every
  // entry to RD_PTR, RD or WR.
  mem_wait_timer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!w_in_wait),
    .cnt_en  (w_cnt_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request fields and the timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write    <= 1'b0;
      r_indirect <= 1'b0;
      r_addr_sel <= 1'b0;
      r_tmo_flag <= 1'b0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_write    <= req_write;
        r_indirect <= req_indirect;
        r_addr_sel <= req_addr_sel;
      end
      if (r_state == DONE) begin
        r_tmo_flag <= 1'b0;
      end else if (w_in_wait && w_expired) begin
        r_tmo_flag <= 1'b1;
      end
    end
  end

  // Next state and Moore output decode; ld_mdr in the read states follows
  // mem_ready directly. Every state enables at most one bus gate.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    marmux_sel   = SEL_ZEXT;
    gate_marmux  = 1'b0;
    gate_mdr     = 1'b0;
    gate_alu     = 1'b0;
    ld_mar       = 1'b0;
    ld_mdr       = 1'b0;
    mdr_from_mem = MDR_SRC_BUS;
    mio_en       = 1'b0;
    r_w          = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = ADDR;
      end
      ADDR: begin
        marmux_sel  = r_addr_sel;
        gate_marmux = 1'b1;
        ld_mar      = 1'b1;
        if (r_indirect)   w_next_state = RD_PTR;
        else if (r_write) w_next_state = WDATA;
        else              w_next_state = RD;
      end
      RD_PTR, RD: begin
        mio_en       = 1'b1;
        mdr_from_mem = MDR_SRC_MEM;
        ld_mdr       = mem_ready;
        // mem_ready takes priority over a simultaneous expiry.
        if (mem_ready)      w_next_state = (r_state == RD_PTR) ? IND : DONE;
        else if (w_expired) w_next_state = DONE;
      end
      IND: begin
        gate_mdr     = 1'b1;
        ld_mar       = 1'b1;
        w_next_state = r_write ? WDATA : RD;
      end
      WDATA: begin
        gate_alu     = 1'b1;
        ld_mdr       = 1'b1;
        w_next_state = WR;
      end
      WR: begin
        mio_en = 1'b1;
        r_w    = 1'b1;
        if (mem_ready || w_expired) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        err          = r_tmo_flag;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_ctrl
// Purpose : Self-checking bench for mem_access_ctrl. Each access is planned
//           as a list of bus cycles (ADDR, memory waits, IND, WDATA, DONE)
//           with the mem_ready value to drive and the strobes expected.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready, req_write, req_indirect, req_addr_sel, mem_ready;
  logic marmux_sel, gate_marmux, gate_mdr, gate_alu, ld_mar, ld_mdr;
  logic mdr_from_mem, mio_en, r_w, done, err;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_indirect (req_indirect),
    .req_addr_sel (req_addr_sel),
    .mem_ready    (mem_ready),
    .marmux_sel   (marmux_sel),
    .gate_marmux  (gate_marmux),
    .gate_mdr     (gate_mdr),
    .gate_alu     (gate_alu),
    .ld_mar       (ld_mar),
    .ld_mdr       (ld_mdr),
    .mdr_from_mem (mdr_from_mem),
    .mio_en       (mio_en),
    .r_w          (r_w),
    .done         (done),
    .err          (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observed outputs packed in a fixed order:
  // {req_ready, marmux_sel, gate_marmux, gate_mdr, gate_alu, ld_mar,
  //  ld_mdr, mdr_from_mem, mio_en, r_w, done, err}
  logic [11:0] w_obs;
  assign w_obs = {req_ready, marmux_sel, gate_marmux, gate_mdr, gate_alu, ld_mar,
                  ld_mdr, mdr_from_mem, mio_en, r_w, done, err};

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] mk(input bit rr, ms, gm, gd, ga, lmar, lmdr, mfm, mio, rw, dn, er);
    return {rr, ms, gm, gd, ga, lmar, lmdr, mfm, mio, rw, dn, er};
  endfunction

  localparam logic [11:0] V_IDLE  = 12'b1000_0000_0000;
  localparam logic [11:0] V_IND   = 12'b0001_0100_0000;
  localparam logic [11:0] V_WDATA = 12'b0000_1010_0000;

  typedef struct packed {
    bit          mr;
    logic [11:0] v;
  } cyc_t;

  cyc_t plan[$];

  // One memory phase that sees n low mem_ready cycles before going ready.
  // A wait that would reach the timeout budget ends after TMO low cycles.
  task automatic add_wait(input bit is_read, input int n, inout bit tmo);
    logic [11:0] v;
    if (n >= TMO) begin
      for (int k = 0; k < TMO; k++) begin
        v = is_read ? mk(0,0,0,0,0,0,0,1,1,0,0,0) : mk(0,0,0,0,0,0,0,0,1,1,0,0);
        plan.push_back('{mr: 1'b0, v: v});
      end
      tmo = 1'b1;
    end else begin
      for (int k = 0; k <= n; k++) begin
        v = is_read ? mk(0,0,0,0,0,0,(k == n),1,1,0,0,0) : mk(0,0,0,0,0,0,0,0,1,1,0,0);
        plan.push_back('{mr: (k == n), v: v});
      end
    end
  endtask

  task automatic build(input bit wr, input bit ind, input bit sel, input int n_ptr, input int n_data);
    bit tmo;
    tmo = 1'b0;
    plan.delete();
    plan.push_back('{mr: 1'($urandom), v: V_IDLE});
    plan.push_back('{mr: 1'($urandom), v: mk(0,sel,1,0,0,1,0,0,0,0,0,0)});
    if (ind) begin
      add_wait(1'b1, n_ptr, tmo);
      if (!tmo) plan.push_back('{mr: 1'($urandom), v: V_IND});
    end
    if (!tmo) begin
      if (wr) begin
        plan.push_back('{mr: 1'($urandom), v: V_WDATA});
        add_wait(1'b0, n_data, tmo);
      end else begin
        add_wait(1'b1, n_data, tmo);
      end
    end
    plan.push_back('{mr: 1'($urandom), v: mk(0,0,0,0,0,0,0,0,0,0,1,tmo)});
  endtask

  task automatic check_gates();
    logic [11:0] cnt;
    cnt = 12'(gate_marmux) + 12'(gate_mdr) + 12'(gate_alu);
    check_eq("gate_onehot", 12'(cnt <= 12'd1), 12'd1);
  endtask

  // Plays one access; abort >= 0 pulls reset in the middle of that cycle.
  task automatic run_access(input bit wr, input bit ind, input bit sel,
                            input int n_ptr, input int n_data,
                            input bit hold_valid, input int abort);
    build(wr, ind, sel, n_ptr, n_data);
    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk);
      #1;
      req_valid    = (i == 0) ? 1'b1 : (hold_valid ? 1'b1 : 1'($urandom));
      req_write    = (i == 0) ? wr  : 1'($urandom);
      req_indirect = (i == 0) ? ind : 1'($urandom);
      req_addr_sel = (i == 0) ? sel : 1'($urandom);
      mem_ready    = plan[i].mr;
      if (i == abort) begin
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", w_obs, V_IDLE);
        check_gates();
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check_eq("rst_hold", w_obs, V_IDLE);
        end
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      check_eq("cycle", w_obs, plan[i].v);
      check_gates();
    end
  endtask

  task automatic idle_gap(input int g);
    for (int i = 0; i < g; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      mem_ready = 1'($urandom);
      @(negedge clk);
      check_eq("idle", w_obs, V_IDLE);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_indirect = 1'b0;
    req_addr_sel = 1'b0;
    mem_ready    = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("reset", w_obs, V_IDLE);
    rst_n = 1'b1;
    idle_gap(1);

    // Direct read through the adder, memory ready at once: done at +3.
    run_access(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);
    // Indirect write via zero-extender, pointer read waits 2 cycles: done at +8.
    run_access(1'b1, 1'b1, 1'b0, 2, 0, 1'b0, -1);
    // Read timing out with mem_ready held low.
    run_access(1'b0, 1'b0, 1'b0, 0, 10, 1'b0, -1);
    // mem_ready rises in the cycle the count would reach the budget.
    run_access(1'b0, 1'b0, 1'b1, 0, TMO - 1, 1'b0, -1);
    // Back-to-back direct reads with req_valid held high.
    run_access(1'b0, 1'b0, 1'b1, 0, 1, 1'b1, -1);
    run_access(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    // Reset in the second WR cycle of a stalled direct write.
    run_access(1'b1, 1'b0, 1'b1, 0, 10, 1'b0, 4);
    idle_gap(1);
    // Indirect write whose pointer read times out and skips the rest.
    run_access(1'b1, 1'b1, 1'b1, 9, 0, 1'b0, -1);
    // Write timing out in WR.
    run_access(1'b1, 1'b0, 1'b0, 0, TMO, 1'b0, -1);

    for (int t = 0; t < 40; t++) begin
      run_access(1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                 1'($urandom), -1);
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer for one LC-3 memory access through the address path: MARMUX select and gate, MAR load, MDR load and memory handshake. Accepts one access request at a time from the main control FSM (LD/ST/LDR/STR/LDI/STI). Raises the MARMUX/MAR/MDR/MIO strobes cycle by cycle, and pulses done when the access completes.
- Guarantees at most one bus gate is active per cycle.

Parameters:
TIMEOUT_CYCLES, 255, max cycles to wait for mem_ready per memory phase; 0 disables the timeout
CNT_W, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  access request
req_ready  out  1  high in IDLE; request accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_indirect  in  1  1 = LDI/STI, read pointer first
req_addr_sel  in  1  MARMUX select for first address: 1 = adder, 0 = zero-extender
mem_ready  in  1  memory ready (LC-3 R)
marmux_sel  out  1  drives MARMUX select
gate_marmux  out  1  MARMUX tri-state enable onto bus
gate_mdr  out  1  MDR tri-state enable onto bus
gate_alu  out  1  ALU gate, sources store data
ld_mar  out  1  MAR load strobe
ld_mdr  out  1  MDR load strobe
mdr_from_mem  out  1  MDR input select: 1 = memory, 0 = bus
mio_en  out  1  memory enable
r_w  out  1  1 = write, 0 = read; valid only while mio_en
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done on timeout

Behaviour:
- Reset state IDLE.
- Reset values: all outputs 0 except req_ready = 1. Latched request fields and the counter clear to 0.
- Reset asserted mid-access returns immediately to IDLE. mio_en and all gates and strobes drop asynchronously, and no done is issued.
- Request fields are latched on acceptance. Inputs are ignored outside IDLE.
- States and outputs. Outputs are Moore decodes of state; only ld_mdr in RD and RD_PTR is Mealy.
  - IDLE: req_ready = 1. On accept go to ADDR.
  - ADDR: marmux_sel = latched req_addr_sel, gate_marmux = 1, ld_mar = 1. Next state:
    - indirect: RD_PTR
    - write: WDATA
    - otherwise: RD
  - RD_PTR: mio_en = 1, r_w = 0, mdr_from_mem = 1, ld_mdr = mem_ready. On mem_ready go to IND.
  - IND: gate_mdr = 1, ld_mar = 1. Next is WDATA if write, else RD.
  - WDATA: gate_alu = 1, ld_mdr = 1, mdr_from_mem = 0. Next is WR.
  - WR: mio_en = 1, r_w = 1. On mem_ready go to DONE.
  - RD: mio_en = 1, r_w = 0, mdr_from_mem = 1, ld_mdr = mem_ready. On mem_ready go to DONE.
  - DONE: done = 1, err = latched timeout flag. Next is IDLE; the timeout flag clears.
- Latency from the accept cycle to the done cycle, with mem_ready high on the first wait cycle:
  - direct read: 3 cycles
  - direct write: 4 cycles
  - indirect read: 5 cycles
  - indirect write: 6 cycles
- Each extra mem_ready-low cycle adds 1.
- Timeout: the counter clears on entry to RD_PTR, RD or WR and increments each cycle mem_ready is low.
  - If count reaches TIMEOUT_CYCLES without mem_ready: set the timeout flag, drop mio_en, go to DONE.
  - On timeout, ld_mdr is never asserted.
  - An indirect access that times out in RD_PTR skips the remaining phases.
- mem_ready and timeout in the same cycle: mem_ready wins, no err.
- Invariant: gate_marmux + gate_mdr + gate_alu ≤ 1 in every cycle, including reset.
- Back-to-back: a new request can be accepted in the cycle after DONE, when state is IDLE again.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE, ADDR, RD_PTR, IND, WDATA, WR, RD, DONE (3-bit)
  - MARMUX select constants: SEL_ADDER = 1, SEL_ZEXT = 0
  - MDR source constants
- One natural sub-module: mem_wait_timer (clear, count-enable, expired output, parameterised CNT_W / TIMEOUT_CYCLES).

Test Plan:
- Reset: rst_n = 0 for 3 cycles mid-WR. Response: mio_en, done and all gates drop at once; req_ready = 1 after release.
- Direct read, req_addr_sel = 1, mem_ready tied high. Response:
  - ADDR: marmux_sel = 1, gate_marmux = 1, ld_mar = 1
  - RD: ld_mdr = 1
  - done high exactly 3 cycles after accept, err = 0
- Indirect write, req_addr_sel = 0, mem_ready low 2 cycles in RD_PTR and high in WR. Response:
  - state sequence ADDR, RD_PTR ×3, IND, WDATA, WR, DONE
  - done 8 cycles after accept
  - IND: gate_mdr = 1 with ld_mar = 1
- Timeout, TIMEOUT_CYCLES = 4, read with mem_ready held low. Response: mio_en high 4 cycles, then done = err = 1 together, ld_mdr never high.
- Boundary: mem_ready rises on the same cycle the count reaches 4. Response: ld_mdr = 1, done with err = 0.
- Back-to-back: req_valid held high for two direct reads. Response: second accept one cycle after the first done; gate one-hot assertion holds throughout.
